stopwatch_timekeeper: RTL and testbench

Timekeeping core of the stopwatch. It converts board-clock cycles into a hundredths-of-a-second tick and keeps a chain of BCD digits. It runs a stopped/running/set state machine driven by the push-button inputs. Its `number` and `set_mode` outputs feed the display multiplexer directly; with the default 4 digits the value reads as SS.hh, with the decimal point after digit 2.

---
 rtl/stopwatch_timekeeper_if.sv | 27 ++
 rtl/stopwatch_timekeeper.sv | 167 ++++++++++++++++
 tb/tb_stopwatch_timekeeper.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_timekeeper_if.sv
// rtl/stopwatch_timekeeper_if.sv - button and display signal bundle for the stopwatch timekeeper
interface stopwatch_timekeeper_if #(
  parameter int NUMBER_OF_DIGITS = 4
);
  // Debounced button levels from the front panel
  logic                          start_stop;
  logic                          clear;
  logic                          set_button;
  logic                          select;
  logic                          increment;
  // Registered state presented to the display multiplexer
  logic [NUMBER_OF_DIGITS*4-1:0] number;
  logic                          set_mode;
  logic [7:0]                    selected_digit;
  logic                          running;
  logic                          rollover;

  modport master (
    output start_stop, clear, set_button, select, increment,
    input  number, set_mode, selected_digit, running, rollover
  );

  modport slave (
    input  start_stop, clear, set_button, select, increment,
    output number, set_mode, selected_digit, running, rollover
  );
endinterface

// File: rtl/stopwatch_timekeeper.sv
// rtl/stopwatch_timekeeper.sv - stopwatch tick prescaler, BCD digit chain and stopped/running/set FSM
module stopwatch_timekeeper #(
  parameter int NUMBER_OF_DIGITS            = 4,
  parameter int TICK_RATE_IN_HZ             = 100,
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  stopwatch_timekeeper_if.slave bus
);

  localparam int DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int NW  = NUMBER_OF_DIGITS * 4;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [7:0]    SEL_MAX   = 8'(NUMBER_OF_DIGITS - 1);

  // Button bit positions inside the synchronizer vectors
  localparam int B_SS  = 0;
  localparam int B_CLR = 1;
  localparam int B_SET = 2;
  localparam int B_SEL = 3;
  localparam int B_INC = 4;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_SET     = 2'd2
  } state_e;

  logic [4:0]    btn_raw;
  logic [4:0]    sync1_q, sync2_q, prev_q, edge_q;
  logic [1:0]    warm_q;

  state_e        state_q, state_d;
  logic [NW-1:0] number_q, number_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sel_q, sel_d;
  logic          rollover_q, rollover_d;

  logic          tick;
  logic [NW-1:0] inc_number;
  logic          wrap;
  logic [3:0]    sel_digit;

  assign btn_raw = {bus.increment, bus.select, bus.set_button, bus.clear, bus.start_stop};

  // Synchronize buttons and register one-cycle rising-edge pulses. Edges are
  // masked until the pipeline has refilled after reset, so a button held
  // through reset release must be released and pressed again to act.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      warm_q  <= (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
      edge_q  <= (warm_q == 2'd3) ? (sync2_q & ~prev_q) : '0;
    end
  end

  // Tick detection and the fully-resolved +1 of the whole BCD chain
  always_comb begin
    logic carry;
    tick       = (state_q == ST_RUNNING) && (presc_q == PRESC_MAX);
    inc_number = number_q;
    carry      = 1'b1;
    for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
      if (carry) begin
        if (number_q[i*4 +: 4] == 4'd9) begin
          inc_number[i*4 +: 4] = 4'd0;
        end else begin
          inc_number[i*4 +: 4] = number_q[i*4 +: 4] + 4'd1;
          carry                = 1'b0;
        end
      end
    end
    wrap      = carry;
    sel_digit = number_q[int'(sel_q)*4 +: 4];
  end

  // State, count, prescaler and selection registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_STOPPED;
      number_q   <= '0;
      presc_q    <= '0;
      sel_q      <= '0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      number_q   <= number_d;
      presc_q    <= presc_d;
      sel_q      <= sel_d;
      rollover_q <= rollover_d;
    end
  end

  // Next-state logic; clear outranks mode changes, which outrank edits and ticks
  always_comb begin
    state_d    = state_q;
    number_d   = number_q;
    presc_d    = presc_q;
    sel_d      = sel_q;
    rollover_d = 1'b0;
    unique case (state_q)
      ST_STOPPED: begin
        presc_d = '0;
        if (edge_q[B_CLR]) number_d = '0;
        if (edge_q[B_SS]) begin
          state_d = ST_RUNNING;
        end else if (edge_q[B_SET]) begin
          state_d = ST_SET;
          sel_d   = '0;
        end
      end
      ST_RUNNING: begin
        if (tick) begin
          number_d   = inc_number;
          presc_d    = '0;
          rollover_d = wrap;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (edge_q[B_CLR]) begin
          number_d   = '0;
          presc_d    = '0;
          rollover_d = 1'b0;
        end
        // A stop in the same cycle as a tick keeps the tick's result
        if (edge_q[B_SS]) begin
          state_d = ST_STOPPED;
          presc_d = '0;
        end
      end
      ST_SET: begin
        presc_d = '0;
        if (edge_q[B_CLR]) begin
          number_d = '0;
        end else if (edge_q[B_INC] && !edge_q[B_SET]) begin
          number_d[int'(sel_q)*4 +: 4] = (sel_digit == 4'd9) ? 4'd0 : sel_digit + 4'd1;
        end
        if (edge_q[B_SET]) begin
          state_d = ST_STOPPED;
          sel_d   = '0;
        end else if (edge_q[B_SEL] && !edge_q[B_INC] && !edge_q[B_CLR]) begin
          sel_d = (sel_q == SEL_MAX) ? 8'd0 : sel_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_STOPPED;
      end
    endcase
  end

  assign bus.number         = number_q;
  assign bus.set_mode       = (state_q == ST_SET);
  assign bus.running        = (state_q == ST_RUNNING);
  assign bus.selected_digit = sel_q;
  assign bus.rollover       = rollover_q;

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// tb/tb_stopwatch_timekeeper.sv - randomized and directed checks of stopwatch_timekeeper against a decimal model
module tb_stopwatch_timekeeper;

  localparam int DIV = 10;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the count kept as a plain decimal integer
  int         m_state;   // 0 stopped, 1 running, 2 set
  int         m_value;
  int         m_pre;
  int         m_sel;
  bit         m_roll;
  logic [4:0] m_prev;
  logic [4:0] pend [3];

  stopwatch_timekeeper_if #(.NUMBER_OF_DIGITS(4)) bus ();

  assign bus.start_stop = btn[0];
  assign bus.clear      = btn[1];
  assign bus.set_button = btn[2];
  assign bus.select     = btn[3];
  assign bus.increment  = btn[4];

  stopwatch_timekeeper #(
    .NUMBER_OF_DIGITS(4),
    .TICK_RATE_IN_HZ(100),
    .BOARD_CLOCK_FREQUENCY_IN_HZ(1000)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_value = 0;
    m_pre   = 0;
    m_sel   = 0;
    m_roll  = 1'b0;
    m_prev  = 5'h1f;   // a button must be seen low before it can count as pressed
    for (int i = 0; i < 3; i++) pend[i] = '0;
  endtask

  // One clock of the model: a press sampled now acts three clocks later
  task automatic model_step();
    logic [4:0] ev;
    logic [4:0] nw;
    bit         tick;
    int         d;
    ev      = pend[2];
    pend[2] = pend[1];
    pend[1] = pend[0];
    nw      = btn & ~m_prev;
    m_prev  = btn;
    pend[0] = nw;
    m_roll  = 1'b0;
    tick    = (m_state == 1) && (m_pre == DIV - 1);
    case (m_state)
      1: begin
        if (tick) begin
          m_value = (m_value + 1) % 10000;
          m_pre   = 0;
          m_roll  = (m_value == 0);
        end else begin
          m_pre++;
        end
        if (ev[1]) begin
          m_value = 0;
          m_pre   = 0;
          m_roll  = 1'b0;
        end
        if (ev[0]) m_state = 0;
      end
      0: begin
        m_pre = 0;
        if (ev[1]) m_value = 0;
        if (ev[0]) m_state = 1;
        else if (ev[2]) begin
          m_state = 2;
          m_sel   = 0;
        end
      end
      default: begin
        m_pre = 0;
        if (ev[1]) begin
          m_value = 0;
        end else if (ev[4] && !ev[2]) begin
          d       = (m_value / pow10(m_sel)) % 10;
          m_value = m_value + (((d + 1) % 10) - d) * pow10(m_sel);
        end
        if (ev[2]) begin
          m_state = 0;
          m_sel   = 0;
        end else if (ev[3] && !ev[4] && !ev[1]) begin
          m_sel = (m_sel + 1) % 4;
        end
      end
    endcase
  endtask

  task automatic check_all();
    check_eq("number", bus.number, to_bcd(m_value));
    check_eq("running", bus.running, (m_state == 1));
    check_eq("set_mode", bus.set_mode, (m_state == 2));
    check_eq("selected_digit", bus.selected_digit, m_sel);
    check_eq("rollover", bus.rollover, m_roll);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input int b, input int hold);
    btn[b] = 1'b1;
    repeat (hold) cyc();
    btn[b] = 1'b0;
    cyc();
  endtask

  task automatic wait_running();
    int n = 0;
    while (!bus.running && n < 20) begin
      cyc();
      n++;
    end
    check_eq("run_wait", bus.running, 1);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    btn   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    check_eq("reset_number", bus.number, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // Run for 250 clocks from the press; first tick lands 10 clocks after running rises
    press(0, 1);
    wait_running();
    t = 0;
    while (bus.number == 16'h0000 && t < 30) begin
      cyc();
      t++;
    end
    check_eq("first_tick", t, 10);
    idle(236);
    check_eq("run250", (bus.number == 16'h0024) || (bus.number == 16'h0025), 1);
    press(0, 1);
    idle(3);
    check_eq("stopped", bus.running, 0);
    idle(100);

    // Set mode editing
    press(1, 1); idle(3);
    press(2, 1); idle(3);
    check_eq("enter_set", bus.set_mode, 1);
    repeat (2) begin press(3, 1); idle(3); end
    check_eq("sel_two", bus.selected_digit, 2);
    repeat (3) begin press(4, 1); idle(3); end
    check_eq("digit2_x3", bus.number, 16'h0300);
    repeat (2) begin press(3, 1); idle(3); end
    check_eq("sel_wrap", bus.selected_digit, 0);
    repeat (10) begin press(4, 1); idle(3); end
    check_eq("digit0_wrap", bus.number, 16'h0300);
    press(0, 1); idle(3);
    check_eq("ss_in_set", bus.set_mode, 1);

    // Load 9999 and roll over
    press(1, 1); idle(3);
    for (int dg = 0; dg < 4; dg++) begin
      repeat (9) begin press(4, 1); idle(3); end
      press(3, 1); idle(3);
    end
    check_eq("load_9999", bus.number, 16'h9999);
    press(2, 1); idle(3);
    check_eq("exit_set", bus.set_mode, 0);
    press(0, 1);
    wait_running();
    idle(9);
    check_eq("pre_roll", bus.number, 16'h9999);
    cyc();
    check_eq("roll_number", bus.number, 16'h0000);
    check_eq("roll_pulse", bus.rollover, 1);
    cyc();
    check_eq("roll_end", bus.rollover, 0);

    // Clear while running at 0042, then clear coincident with a tick
    t = 0;
    while (bus.number != 16'h0042 && t < 1000) begin
      cyc();
      t++;
    end
    check_eq("reach_42", bus.number, 16'h0042);
    press(1, 1); idle(2);
    check_eq("clr_run_num", bus.number, 16'h0000);
    check_eq("clr_run_state", bus.running, 1);
    idle(50);
    t = 0;
    while (m_pre != 6 && t < 20) begin
      cyc();
      t++;
    end
    press(1, 1); idle(2);
    check_eq("clr_tick_num", bus.number, 16'h0000);
    check_eq("clr_tick_roll", bus.rollover, 0);

    // Inputs ignored while running, and a held button acting once
    idle(25);
    press(2, 1); idle(3);
    check_eq("setb_ignored", bus.set_mode, 0);
    press(4, 1); idle(3);
    check_eq("inc_ignored", bus.running, 1);
    press(0, 30); idle(3);
    check_eq("held_once", bus.running, 0);
    press(0, 1); idle(3);
    check_eq("restart", bus.running, 1);

    // Asynchronous reset between edges, start_stop held through release
    idle(37);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_number", bus.number, 16'h0000);
    check_eq("arst_running", bus.running, 0);
    check_eq("arst_roll", bus.rollover, 0);
    check_eq("arst_set", bus.set_mode, 0);
    check_eq("arst_sel", bus.selected_digit, 0);
    model_reset();
    btn[0] = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(10);
    check_eq("held_at_release", bus.running, 0);
    btn[0] = 1'b0;
    idle(5);
    press(0, 1); idle(3);
    check_eq("rearm", bus.running, 1);

    // Random button traffic
    repeat (200) begin
      press($urandom_range(0, 4), $urandom_range(1, 3));
      idle($urandom_range(2, 25));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
